sdm_ramp_ctrl: RTL

Sequencer for the MASH 1-1-1 sigma-delta modulator in the fractional-N path. It owns the modulator's input word and its active-low flush reset. It brings the modulator up through a fixed flush interval, accepts new target words over a valid/ready handshake, and slews the input word toward each target in programmable steps and dwell times, so the modulator never sees an abrupt input jump unless one is requested.

---
 rtl/sdm_ramp_ctrl_if.sv | 16 +
 rtl/sdm_ramp_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sdm_ramp_ctrl_if.sv
// Target-word handshake between a frequency-plan source and sdm_ramp_ctrl.
// The source offers a word with its ramp step and dwell; the controller accepts it.
interface sdm_ramp_ctrl_if #(
    parameter int W       = 10,
    parameter int STEP_W  = 4,
    parameter int DWELL_W = 8
);
    logic [W-1:0]       tgt_data;
    logic               tgt_valid;
    logic               tgt_ready;
    logic [STEP_W-1:0]  step;
    logic [DWELL_W-1:0] dwell;

    modport master (output tgt_data, tgt_valid, step, dwell, input tgt_ready);
    modport slave  (input tgt_data, tgt_valid, step, dwell, output tgt_ready);
endinterface

// File: rtl/sdm_ramp_ctrl.sv
// Sequencer for the MASH 1-1-1 modulator: flushes it on start-up, then slews its
// input word toward each accepted target in programmable steps and dwell times.
module sdm_ramp_ctrl #(
    parameter int W         = 10,
    parameter int STEP_W    = 4,
    parameter int DWELL_W   = 8,
    parameter int FLUSH_CYC = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    sdm_ramp_ctrl_if.slave tgt,
    output logic [W-1:0]   sdm_din,
    output logic           sdm_rstn,
    output logic           busy,
    output logic           locked,
    output logic           ramp_done
);

    localparam int FLUSH_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {OFF, FLUSH, HOLD, RAMP} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       din_q, din_d;
    logic [W-1:0]       tgt_q, tgt_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic               done_d;
    logic               hold_q, busy_q, rstn_q, done_q;

    logic signed [W:0]  diff;
    logic [W:0]         mag;
    logic [W:0]         step_ext;
    logic [W-1:0]       ramp_next;

    // One ramp update: land on the target when within one step, otherwise move by a full step.
    always_comb begin
        diff      = $signed({1'b0, tgt_q}) - $signed({1'b0, din_q});
        mag       = diff[W] ? (W+1)'(-diff) : (W+1)'(diff);
        step_ext  = (W+1)'(step_q);
        ramp_next = tgt_q;
        if (step_q != '0 && mag > step_ext)
            ramp_next = diff[W] ? din_q - W'(step_q) : din_q + W'(step_q);
    end

    always_comb begin
        // NOTE: every variable gets its default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        din_d       = din_q;
        tgt_d       = tgt_q;
        step_d      = step_q;
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_cnt_q;
        flush_cnt_d = flush_cnt_q;
        done_d      = 1'b0;

        if (!enable) begin
            state_d     = OFF;
            din_d       = '0;
            tgt_d       = '0;
            dwell_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            unique case (state_q)
                OFF: begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
                FLUSH: begin
                    if (flush_cnt_q == '0) state_d = HOLD;
                    else                   flush_cnt_d = flush_cnt_q - 1'b1;
                end
                HOLD: begin
                    if (tgt.tgt_valid && hold_q) begin
                        tgt_d       = tgt.tgt_data;
                        step_d      = tgt.step;
                        dwell_d     = tgt.dwell;
                        dwell_cnt_d = tgt.dwell;
                        if (tgt.tgt_data != din_q) state_d = RAMP;
                        else                       done_d  = 1'b1;
                    end
                end
                RAMP: begin
                    if (dwell_cnt_q == '0) begin
                        dwell_cnt_d = dwell_q;
                        din_d       = ramp_next;
                        if (ramp_next == tgt_q) begin
                            state_d = HOLD;
                            done_d  = 1'b1;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with sdm_din.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= OFF;
            din_q       <= '0;
            tgt_q       <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            flush_cnt_q <= '0;
            hold_q      <= 1'b0;
            busy_q      <= 1'b0;
            rstn_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from the same pre-edge values.
            state_q     <= state_d;
            din_q       <= din_d;
            tgt_q       <= tgt_d;
            step_q      <= step_d;
            dwell_q     <= dwell_d;
            dwell_cnt_q <= dwell_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            hold_q      <= (state_d == HOLD);
            busy_q      <= (state_d == FLUSH) || (state_d == RAMP);
            rstn_q      <= (state_d == HOLD) || (state_d == RAMP);
            done_q      <= done_d;
        end
    end

    assign tgt.tgt_ready = hold_q;
    assign locked        = hold_q;
    assign busy          = busy_q;
    assign sdm_rstn      = rstn_q;
    assign sdm_din       = din_q;
    assign ramp_done     = done_q;

endmodule
